hazard_unit_mc: RTL and testbench

//   Hazard/forwarding controller for the 5-stage pipeline, extended with a multi-cycle

---
 rtl/hazard_pkg.sv | 14 +
 rtl/div_stall_fsm.sv | 60 ++++++
 rtl/hazard_unit_mc.sv | 96 +++++++++
 tb/tb_hazard_unit_mc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and divide-interlock FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divide interlock: holds E for DIV_CYCLES cycles, then strobes div_done for one cycle.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic divE_i,
  output logic divstall_o,
  output logic div_busy_o,
  output logic div_done_o
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divstall_o = 1'b0;
    div_busy_o = 1'b0;
    div_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        // The entry cycle already stalls, so BUSY only covers the remaining DIV_CYCLES-1.
        if (divE_i) begin
          divstall_o = 1'b1;
          state_d    = BUSY;
          cnt_d      = CNT_W'(DIV_CYCLES - 2);
        end
      end
      BUSY: begin
        divstall_o = 1'b1;
        div_busy_o = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        // divE still shows the finishing divide here; it must not restart the count.
        div_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Forwarding/stall controller for the 5-stage pipeline; the divide interlock exists only
// when HAZARD_DIV_STALL_EN is defined.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rsD_i,
  input  logic [REG_AW-1:0] rtD_i,
  input  logic              branchD_i,
  input  logic [REG_AW-1:0] rsE_i,
  input  logic [REG_AW-1:0] rtE_i,
  input  logic [REG_AW-1:0] writeregE_i,
  input  logic              regwriteE_i,
  input  logic              memtoregE_i,
  input  logic              divE_i,
  input  logic [REG_AW-1:0] writeregM_i,
  input  logic              regwriteM_i,
  input  logic              memtoregM_i,
  input  logic [REG_AW-1:0] writeregW_i,
  input  logic              regwriteW_i,
  output logic              stallF_o,
  output logic              stallD_o,
  output logic              stallE_o,
  output logic              flushE_o,
  output logic              flushM_o,
  output logic              forwardaD_o,
  output logic              forwardbD_o,
  output logic [1:0]        forwardaE_o,
  output logic [1:0]        forwardbE_o,
  output logic              div_busy_o,
  output logic              div_done_o
);

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] wr_m, input logic we_m,
                                       input logic [REG_AW-1:0] wr_w, input logic we_w);
    if (src != '0 && src == wr_m && we_m)      return FWD_MEM;
    else if (src != '0 && src == wr_w && we_w) return FWD_WB;
    else                                       return FWD_NONE;
  endfunction

  logic divstall, div_busy, div_done;
  logic lwstall, brstall, hold_fd;
  logic fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

`ifdef HAZARD_DIV_STALL_EN
  div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div_fsm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .divE_i     (divE_i),
    .divstall_o (divstall),
    .div_busy_o (div_busy),
    .div_done_o (div_done)
  );
`else
  localparam int unused_div_cycles = DIV_CYCLES;
  logic unused_div;
  assign unused_div = ^{clk_i, divE_i};
  assign divstall   = 1'b0;
  assign div_busy   = 1'b0;
  assign div_done   = 1'b0;
`endif

  assign fwd_ae = fwd_e(rsE_i, writeregM_i, regwriteM_i, writeregW_i, regwriteW_i);
  assign fwd_be = fwd_e(rtE_i, writeregM_i, regwriteM_i, writeregW_i, regwriteW_i);
  assign fwd_ad = (rsD_i != '0) && (rsD_i == writeregM_i) && regwriteM_i;
  assign fwd_bd = (rtD_i != '0) && (rtD_i == writeregM_i) && regwriteM_i;

  assign lwstall = memtoregE_i && (writeregE_i != '0) &&
                   (writeregE_i == rsD_i || writeregE_i == rtD_i);
  assign brstall = branchD_i &&
                   ((regwriteE_i && writeregE_i != '0 &&
                     (writeregE_i == rsD_i || writeregE_i == rtD_i)) ||
                    (memtoregM_i && writeregM_i != '0 &&
                     (writeregM_i == rsD_i || writeregM_i == rtD_i)));
  assign hold_fd = lwstall | brstall | divstall;

  // Everything is forced quiet while reset is asserted, including the combinational paths.
  assign stallF_o    = rst_i & hold_fd;
  assign stallD_o    = rst_i & hold_fd;
  assign stallE_o    = rst_i & divstall;
  assign flushM_o    = rst_i & divstall;
  assign flushE_o    = rst_i & (lwstall | brstall) & ~divstall;
  assign div_busy_o  = rst_i & div_busy;
  assign div_done_o  = rst_i & div_done;
  assign forwardaD_o = rst_i & fwd_ad;
  assign forwardbD_o = rst_i & fwd_bd;
  assign forwardaE_o = rst_i ? fwd_ae : FWD_NONE;
  assign forwardbE_o = rst_i ? fwd_be : FWD_NONE;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc (DIV_CYCLES=4); divide expectations follow HAZARD_DIV_STALL_EN.
module tb_hazard_unit_mc;

`ifdef HAZARD_DIV_STALL_EN
  localparam bit DIVEN = 1'b1;
`else
  localparam bit DIVEN = 1'b0;
`endif

  // {stallF,stallD,stallE,flushE,flushM,div_busy,div_done}
  localparam logic [6:0] S_NONE  = 7'b0000000;
  localparam logic [6:0] S_HAZ   = 7'b1101000;
  localparam logic [6:0] S_START = DIVEN ? 7'b1110100 : 7'b0000000;
  localparam logic [6:0] S_BUSY  = DIVEN ? 7'b1110110 : 7'b0000000;
  localparam logic [6:0] S_DONE  = DIVEN ? 7'b0000001 : 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, regwriteE, memtoregE, divE, regwriteM, memtoregM, regwriteW;
  logic       stallF, stallD, stallE, flushE, flushM, forwardaD, forwardbD, div_busy, div_done;
  logic [1:0] forwardaE, forwardbE;

  hazard_unit_mc #(.REG_AW(5), .DIV_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .rsD_i(rsD), .rtD_i(rtD), .branchD_i(branchD),
    .rsE_i(rsE), .rtE_i(rtE), .writeregE_i(writeregE),
    .regwriteE_i(regwriteE), .memtoregE_i(memtoregE), .divE_i(divE),
    .writeregM_i(writeregM), .regwriteM_i(regwriteM), .memtoregM_i(memtoregM),
    .writeregW_i(writeregW), .regwriteW_i(regwriteW),
    .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE),
    .flushE_o(flushE), .flushM_o(flushM),
    .forwardaD_o(forwardaD), .forwardbD_o(forwardbD),
    .forwardaE_o(forwardaE), .forwardbE_o(forwardbE),
    .div_busy_o(div_busy), .div_done_o(div_done)
  );

  logic [6:0] st;
  logic [5:0] fw;
  assign st = {stallF, stallD, stallE, flushE, flushM, div_busy, div_done};
  assign fw = {forwardaD, forwardbD, forwardaE, forwardbE};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0; writeregE = 0;
    regwriteE = 0; memtoregE = 0; divE = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 0; regwriteW = 0;
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset with hazards and a divide presented: everything must stay 0.
    idle();
    rst = 0; divE = 1; regwriteM = 1; writeregM = 3; rsE = 3; rsD = 3;
    branchD = 1; regwriteE = 1; writeregE = 3;
    settle();
    chk("rst_st_during", {1'b0, st}, {1'b0, S_NONE});
    chk("rst_fw_during", {2'b0, fw}, 8'h00);
    tick(); settle();
    chk("rst_st_after_edge", {1'b0, st}, {1'b0, S_NONE});
    tick(); rst = 1; idle(); settle();
    chk("idle_st", {1'b0, st}, {1'b0, S_NONE});

    // 1: E forwarding priority and zero register
    tick(); idle();
    writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1; rsE = 3; rtE = 5; rsD = 3;
    settle();
    chk("fwdE_mem", {2'b0, fw}, {2'b0, 1'b1, 1'b0, 2'b10, 2'b00});
    regwriteM = 0; settle();
    chk("fwdE_wb", {2'b0, fw}, {2'b0, 1'b0, 1'b0, 2'b01, 2'b00});
    rsE = 0; rtE = 3; settle();
    chk("fwdE_zero_src", {2'b0, fw}, {2'b0, 1'b0, 1'b0, 2'b00, 2'b01});
    regwriteM = 1; settle();
    chk("fwdE_b_mem_prio", {2'b0, fw}, {2'b0, 1'b1, 1'b0, 2'b00, 2'b10});
    writeregM = 0; writeregW = 0; rsE = 0; rtE = 0; rsD = 0; rtD = 0; settle();
    chk("fwd_r0_never", {2'b0, fw}, 8'h00);
    chk("fwd_no_stall", {1'b0, st}, {1'b0, S_NONE});

    // 2: load-use on rsD, bubble, then load reaches W
    tick(); idle(); memtoregE = 1; regwriteE = 1; writeregE = 2; rsD = 2; settle();
    chk("lw_rs", {1'b0, st}, {1'b0, S_HAZ});
    rsD = 0; rtD = 2; settle();
    chk("lw_rt", {1'b0, st}, {1'b0, S_HAZ});
    writeregE = 0; rtD = 0; settle();
    chk("lw_r0", {1'b0, st}, {1'b0, S_NONE});
    tick(); idle(); memtoregM = 1; regwriteM = 1; writeregM = 2; rsD = 2; settle();
    chk("lw_in_M_st", {1'b0, st}, {1'b0, S_NONE});
    chk("lw_in_M_fwdD", {2'b0, fw}, {2'b0, 1'b1, 1'b0, 2'b00, 2'b00});
    tick(); idle(); regwriteW = 1; writeregW = 2; rsE = 2; settle();
    chk("lw_in_W_fwdE", {2'b0, fw}, {2'b0, 1'b0, 1'b0, 2'b01, 2'b00});

    // 3: branch hazards
    tick(); idle(); branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4; settle();
    chk("br_aluE", {1'b0, st}, {1'b0, S_HAZ});
    tick(); idle(); branchD = 1; rsD = 4; regwriteM = 1; writeregM = 4; settle();
    chk("br_resolved_st", {1'b0, st}, {1'b0, S_NONE});
    chk("br_resolved_fwdD", {2'b0, fw}, {2'b0, 1'b1, 1'b0, 2'b00, 2'b00});
    tick(); idle(); branchD = 1; rtD = 5; memtoregM = 1; regwriteM = 1; writeregM = 5; settle();
    chk("br_loadM", {1'b0, st}, {1'b0, S_HAZ});
    branchD = 0; settle();
    chk("nobr_loadM", {1'b0, st}, {1'b0, S_NONE});

    // 4: single divide, with a branch hazard and forwarding during BUSY
    tick(); idle(); divE = 1; settle();
    chk("div_start", {1'b0, st}, {1'b0, S_START});
    tick(); settle();
    chk("div_busy1", {1'b0, st}, {1'b0, S_BUSY});
    tick();
    branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4; regwriteM = 1; writeregM = 6; rsE = 6;
    settle();
    chk("div_busy2_br", {1'b0, st}, {1'b0, DIVEN ? 7'b1110110 : S_HAZ});
    chk("div_busy2_fwd", {2'b0, fw}, {2'b0, 1'b0, 1'b0, 2'b10, 2'b00});
    tick(); idle(); divE = 1; settle();
    chk("div_busy3", {1'b0, st}, {1'b0, S_BUSY});
    tick(); settle();
    chk("div_done", {1'b0, st}, {1'b0, S_DONE});
    tick(); idle(); settle();
    chk("div_after", {1'b0, st}, {1'b0, S_NONE});

    // 5: reset on the 2nd BUSY cycle aborts the divide
    tick(); divE = 1; settle();
    chk("abort_start", {1'b0, st}, {1'b0, S_START});
    tick(); tick(); rst = 0; settle();
    chk("abort_in_rst", {1'b0, st}, {1'b0, S_NONE});
    tick(); rst = 1; divE = 0; settle();
    chk("abort_no_done", {1'b0, st}, {1'b0, S_NONE});
    tick(); settle();
    chk("abort_quiet", {1'b0, st}, {1'b0, S_NONE});
    divE = 1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("restart_c%0d", i), {1'b0, st},
          {1'b0, (i == 0) ? S_START : (i == 4) ? S_DONE : S_BUSY});
      tick();
    end
    divE = 0; settle();
    chk("restart_after", {1'b0, st}, {1'b0, S_NONE});

    // 6: back-to-back divides with no gap cycle
    tick(); divE = 1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("b2b_c%0d", i), {1'b0, st},
          {1'b0, (i % 5 == 0) ? S_START : (i % 5 == 4) ? S_DONE : S_BUSY});
      tick();
    end
    divE = 0; settle();
    chk("b2b_after", {1'b0, st}, {1'b0, S_NONE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
